// File: rtl/counter_sweep_ctrl.sv
// Sequencer for an up/down counter: seeks to lo, then ping-pongs lo<->hi for N sweeps.
// Optional `pause` input is compiled in when COUNTER_SWEEP_PAUSE_EN is defined.
module counter_sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int SWEEP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
`ifdef COUNTER_SWEEP_PAUSE_EN
    input  logic               pause,
`endif
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [SWEEP_W-1:0] sweeps,
    input  logic [WIDTH-1:0]   counter_out,
    output logic               enable,
    output logic               direction,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SWEEP_W-1:0] sweep_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_SEEK, S_UP, S_DOWN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
    logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d, sweep_nxt;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               pause_w, running;

`ifdef COUNTER_SWEEP_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    assign running   = (state_q == S_SEEK) || (state_q == S_UP) || (state_q == S_DOWN);
    assign sweep_nxt = sweep_cnt_q + SWEEP_W'(1);

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        sweeps_d    = sweeps_q;
        sweep_cnt_d = sweep_cnt_q;
        err_d       = 1'b0;
        enable      = 1'b0;
        direction   = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (lo < hi) begin
                        lo_d        = lo;
                        hi_d        = hi;
                        sweeps_d    = sweeps;
                        sweep_cnt_d = '0;
                        state_d     = S_SEEK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SEEK: begin
                if (counter_out > lo_q) begin
                    enable    = 1'b1;
                    direction = 1'b0;
                end else if (counter_out < lo_q) begin
                    enable    = 1'b1;
                    direction = 1'b1;
                end else begin
                    state_d = S_UP;
                end
            end
            S_UP: begin
                enable = 1'b1;
                if (counter_out < hi_q) begin
                    direction = 1'b1;
                end else begin
                    // Reverse on the same cycle hi is seen so there is no dead cycle.
                    direction = 1'b0;
                    state_d   = S_DOWN;
                end
            end
            S_DOWN: begin
                if (counter_out > lo_q) begin
                    enable    = 1'b1;
                    direction = 1'b0;
                end else begin
                    sweep_cnt_d = sweep_nxt;
                    if ((sweeps_q != '0) && (sweep_nxt == sweeps_q)) begin
                        state_d = S_DONE;
                    end else begin
                        enable    = 1'b1;
                        direction = 1'b1;
                        state_d   = S_UP;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // stop beats pause; both freeze the counter before any turn decision lands.
        if (running && (stop || pause_w)) begin
            enable      = 1'b0;
            sweep_cnt_d = sweep_cnt_q;
            state_d     = stop ? S_IDLE : state_q;
        end

        if (rst) begin
            enable    = 1'b0;
            direction = 1'b1;
        end

        busy_d = (state_d == S_SEEK) || (state_d == S_UP) || (state_d == S_DOWN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            sweeps_q    <= '0;
            sweep_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            sweeps_q    <= sweeps_d;
            sweep_cnt_q <= sweep_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl, with a behavioural up/down counter in the loop.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause;
    logic [7:0] lo, hi, cnt, ld_val;
    logic [3:0] sweeps, sweep_cnt;
    logic       enable, direction, busy, done, err, ld;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    counter_sweep_ctrl #(.WIDTH(8), .SWEEP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef COUNTER_SWEEP_PAUSE_EN
        .pause(pause),
`endif
        .lo(lo), .hi(hi), .sweeps(sweeps), .counter_out(cnt),
        .enable(enable), .direction(direction), .busy(busy), .done(done),
        .err(err), .sweep_cnt(sweep_cnt)
    );

    // Counter being driven; ld lets the bench preset its value.
    always @(posedge clk) begin
        if (ld) cnt <= ld_val;
        else if (enable) cnt <= direction ? cnt + 8'd1 : cnt - 8'd1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_cnt(input logic [7:0] v);
        ld = 1'b1; ld_val = v;
        tick();
        ld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; stop = 0; pause = 0; lo = 0; hi = 0; sweeps = 0;
        ld = 1'b1; ld_val = 8'd0;
        tick(); tick();
        n_chk++;
        if ({busy, done, err, sweep_cnt, enable, direction} !== {3'b000, 4'd0, 2'b01}) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b err=%b sc=%0d en=%b dir=%b, want 0 0 0 0 0 1",
                     busy, done, err, sweep_cnt, enable, direction);
        end
        rst = 1'b0; ld = 1'b0;
        tick();
    endtask

    task automatic test_seek_up();
        int done_k = -1, done_n = 0, maxc = 0;
        lo = 2; hi = 5; sweeps = 1; start = 1;
        tick(); start = 0;
        for (int k = 1; k <= 30; k++) begin
            if (done) begin done_n++; if (done_k < 0) done_k = k; end
            if (int'(cnt) > maxc) maxc = int'(cnt);
            if (k == 1) begin
                n_chk++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", busy); end
            end
            if (k == 3) begin
                n_chk++;
                if (cnt !== 8'd2 || enable !== 1'b0) begin
                    n_fail++; $display("FAIL t1_dead_cycle: got cnt=%0d en=%b want 2 0", cnt, enable);
                end
            end
            tick();
        end
        n_chk++;
        if (done_k != 11 || done_n != 1) begin
            n_fail++; $display("FAIL t1_done: got cycle=%0d pulses=%0d want 11 1", done_k, done_n);
        end
        n_chk++;
        if (sweep_cnt !== 4'd1 || enable !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t1_final: got sc=%0d en=%b busy=%b want 1 0 0", sweep_cnt, enable, busy);
        end
        n_chk++;
        if (maxc > 5) begin n_fail++; $display("FAIL t1_range: got max=%0d want <=5", maxc); end
    endtask

    task automatic test_two_sweeps();
        int done_k = -1, k1 = -1, k2 = -1, maxc = 0, minc = 255;
        load_cnt(8'd10);
        lo = 3; hi = 6; sweeps = 2; start = 1;
        tick(); start = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done && done_k < 0) done_k = k;
            if (sweep_cnt == 4'd1 && k1 < 0) k1 = k;
            if (sweep_cnt == 4'd2 && k2 < 0) k2 = k;
            if (int'(cnt) > maxc) maxc = int'(cnt);
            if (int'(cnt) < minc) minc = int'(cnt);
            tick();
        end
        n_chk++;
        if (k1 != 16 || k2 != 22) begin
            n_fail++; $display("FAIL t2_sweep_cnt: got k1=%0d k2=%0d want 16 22", k1, k2);
        end
        n_chk++;
        if (done_k != 22) begin n_fail++; $display("FAIL t2_done: got %0d want 22", done_k); end
        n_chk++;
        if (maxc > 10 || minc < 3) begin
            n_fail++; $display("FAIL t2_range: got [%0d,%0d] want within [3,10]", minc, maxc);
        end
        n_chk++;
        if (enable !== 1'b0 || cnt !== 8'd3) begin
            n_fail++; $display("FAIL t2_final: got en=%b cnt=%0d want 0 3", enable, cnt);
        end
    endtask

    task automatic test_err();
        lo = 7; hi = 7; sweeps = 1; start = 1;
        #1;
        n_chk++;
        if (enable !== 1'b0) begin n_fail++; $display("FAIL t3_en: got %b want 0", enable); end
        tick(); start = 0;
        n_chk++;
        if (err !== 1'b1 || busy !== 1'b0 || enable !== 1'b0) begin
            n_fail++; $display("FAIL t3_err: got err=%b busy=%b en=%b want 1 0 0", err, busy, enable);
        end
        tick();
        n_chk++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t3_pulse: got err=%b busy=%b want 0 0", err, busy);
        end
    endtask

    task automatic test_continuous_stop();
        logic [3:0] prev;
        bit saw_done = 0, saw_wrap = 0, found = 0;
        int w = 0;
        load_cnt(8'd0);
        lo = 0; hi = 3; sweeps = 0; start = 1;
        tick(); start = 0;
        prev = sweep_cnt;
        for (int k = 0; k < 110; k++) begin
            if (done) saw_done = 1;
            if (prev == 4'd15 && sweep_cnt == 4'd0) saw_wrap = 1;
            prev = sweep_cnt;
            tick();
        end
        n_chk++;
        if (saw_done || !saw_wrap || busy !== 1'b1) begin
            n_fail++; $display("FAIL t4_continuous: got done=%0d wrap=%0d busy=%b want 0 1 1", saw_done, saw_wrap, busy);
        end
        while (!found && w < 20) begin
            if (cnt == 8'd2 && enable && direction) found = 1;
            else begin tick(); w++; end
        end
        n_chk++;
        if (!found) begin n_fail++; $display("FAIL t4_find_up2: got timeout want UP at 2"); end
        stop = 1; #1;
        n_chk++;
        if (enable !== 1'b0) begin n_fail++; $display("FAIL t4_stop_comb: got en=%b want 0", enable); end
        tick(); stop = 0;
        n_chk++;
        if (busy !== 1'b0 || enable !== 1'b0 || done !== 1'b0 || cnt !== 8'd2) begin
            n_fail++; $display("FAIL t4_stopped: got busy=%b en=%b done=%b cnt=%0d want 0 0 0 2", busy, enable, done, cnt);
        end
        tick();
        n_chk++;
        if (done !== 1'b0 || cnt !== 8'd2) begin
            n_fail++; $display("FAIL t4_hold: got done=%b cnt=%0d want 0 2", done, cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        bit found = 0;
        int w = 0, done_k = -1, sc_at_done = -1;
        lo = 1; hi = 4; sweeps = 3; start = 1;
        tick(); start = 0;
        while (!found && w < 40) begin
            if (sweep_cnt == 4'd1 && cnt == 8'd4 && !direction) found = 1;
            else begin tick(); w++; end
        end
        tick();
        n_chk++;
        if (!found || cnt !== 8'd3 || enable !== 1'b1 || direction !== 1'b0) begin
            n_fail++; $display("FAIL t5_in_down: got found=%0d cnt=%0d en=%b dir=%b want 1 3 1 0", found, cnt, enable, direction);
        end
        rst = 1; #1;
        n_chk++;
        if (enable !== 1'b0 || direction !== 1'b1) begin
            n_fail++; $display("FAIL t5_rst_comb: got en=%b dir=%b want 0 1", enable, direction);
        end
        tick(); rst = 0;
        n_chk++;
        if (busy !== 1'b0 || sweep_cnt !== 4'd0 || enable !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL t5_after_rst: got busy=%b sc=%0d en=%b done=%b want 0 0 0 0", busy, sweep_cnt, enable, done);
        end
        lo = 1; hi = 2; sweeps = 1; start = 1;
        tick(); start = 0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 2) begin start = 1; lo = 0; hi = 9; end
            if (k == 3) start = 0;
            if (done && done_k < 0) begin done_k = k; sc_at_done = int'(sweep_cnt); end
            tick();
        end
        n_chk++;
        if (done_k != 7 || sc_at_done != 1) begin
            n_fail++; $display("FAIL t5_restart: got done_k=%0d sc=%0d want 7 1", done_k, sc_at_done);
        end
    endtask

`ifdef COUNTER_SWEEP_PAUSE_EN
    task automatic test_pause();
        bit found = 0;
        int w = 0;
        load_cnt(8'd0);
        lo = 0; hi = 4; sweeps = 1; start = 1;
        tick(); start = 0;
        while (!found && w < 20) begin
            if (cnt == 8'd4 && busy) found = 1;
            else begin tick(); w++; end
        end
        pause = 1; #1;
        n_chk++;
        if (!found || enable !== 1'b0) begin
            n_fail++; $display("FAIL tp_pause_en: got found=%0d en=%b want 1 0", found, enable);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_chk++;
            if (cnt !== 8'd4 || enable !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL tp_hold: got cnt=%0d en=%b busy=%b want 4 0 1", cnt, enable, busy);
            end
        end
        tick();
        pause = 0; #1;
        n_chk++;
        if (cnt !== 8'd4 || enable !== 1'b1 || direction !== 1'b0) begin
            n_fail++; $display("FAIL tp_turn: got cnt=%0d en=%b dir=%b want 4 1 0", cnt, enable, direction);
        end
        tick();
        n_chk++;
        if (cnt !== 8'd3) begin n_fail++; $display("FAIL tp_after: got cnt=%0d want 3", cnt); end
        for (int k = 0; k < 20; k++) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_seek_up();
        test_two_sweeps();
        test_err();
        test_continuous_stop();
        test_reset_mid_run();
`ifdef COUNTER_SWEEP_PAUSE_EN
        test_pause();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
